// File: rtl/nebula_pkg.sv
// Shared constants and types for the nebula router switch allocator.
package nebula_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int PORT_LOCAL  = 4;
  localparam int NUM_VCS     = 2;
  localparam int NUM_CREDITS = 4;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
  typedef logic [$clog2(NUM_VCS)-1:0]   vc_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t in;
    vc_idx_t   vc;
  } lock_t;

endpackage

// File: rtl/nebula_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
// Purely combinational, 0 cycles; never stalls, any_grant is 0 when nothing requests.
module nebula_rr_arb #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any_grant
);

  // First pass covers [ptr, N-1]; second pass only matters for the wrapped part [0, ptr-1].
  always_comb begin
    gnt       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[k] && (k >= int'(ptr))) begin
        gnt[k]    = 1'b1;
        any_grant = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[k]) begin
        gnt[k]    = 1'b1;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nebula_sw_alloc.sv
// Switch allocator and output-credit manager: separable input-then-output round-robin, wormhole locks.
// Grants are combinational (0 cycles); an input-VC stalls while its output has no credit or is locked to another.
module nebula_sw_alloc
  import nebula_pkg::*;
#(
  parameter int PORTS   = NUM_PORTS,
  parameter int VCS     = NUM_VCS,
  parameter int CREDITS = NUM_CREDITS,
  parameter int PORT_W  = $clog2(PORTS),
  parameter int CRED_W  = $clog2(CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*VCS-1:0]        req_valid,
  input  logic [PORTS*VCS-1:0]        req_head,
  input  logic [PORTS*VCS-1:0]        req_tail,
  input  logic [PORTS*VCS*PORT_W-1:0] req_port,
  input  logic [PORTS*VCS-1:0]        credit_ret,
  output logic [PORTS*VCS-1:0]        grant,
  output logic [PORTS-1:0]            xbar_valid,
  output logic [PORTS*PORT_W-1:0]     xbar_sel,
  output logic [PORTS*$clog2(VCS)-1:0] xbar_vc,
  output logic [PORTS-1:0]            congest
);

  localparam int VC_W = $clog2(VCS);

  lock_t             lock       [PORTS];
  logic [CRED_W-1:0] credit     [PORTS][VCS];
  logic [CRED_W-1:0] credit_nxt [PORTS][VCS];
  logic [VC_W-1:0]   in_ptr     [PORTS];
  logic [PORT_W-1:0] out_ptr    [PORTS];

  logic [PORT_W-1:0] tgt      [PORTS][VCS];
  logic [VCS-1:0]    elig     [PORTS];
  logic [VCS-1:0]    in_gnt   [PORTS];
  logic [PORTS-1:0]  in_any;
  logic [VC_W-1:0]   win_vc   [PORTS];
  logic [PORT_W-1:0] win_port [PORTS];
  logic [PORTS-1:0]  out_req  [PORTS];
  logic [PORTS-1:0]  out_gnt  [PORTS];
  logic [PORTS-1:0]  out_any;
  logic [PORTS-1:0]  in_won;
  logic [PORT_W-1:0] sel      [PORTS];
  logic [VC_W-1:0]   svc      [PORTS];
  logic [PORTS-1:0]  shead;
  logic [PORTS-1:0]  stail;
  logic [VCS-1:0]    dec      [PORTS];
  logic [PORTS-1:0]  congest_nxt;

  // Out-of-range targets never match any o, so they are never eligible.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      for (int v = 0; v < VCS; v++) begin
        tgt[i][v]  = req_port[(i*VCS+v)*PORT_W +: PORT_W];
        elig[i][v] = 1'b0;
        for (int o = 0; o < PORTS; o++) begin
          if (req_valid[i*VCS+v] && tgt[i][v] == PORT_W'(o) && credit[o][v] != '0) begin
            elig[i][v] = lock[o].valid
                       ? (lock[o].in == port_idx_t'(i) && lock[o].vc == vc_idx_t'(v))
                       : req_head[i*VCS+v];
          end
        end
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < PORTS; gi++) begin : g_arb
    nebula_rr_arb #(.N(VCS), .PTR_W(VC_W)) u_in_arb (
      .req       (elig[gi]),
      .ptr       (in_ptr[gi]),
      .gnt       (in_gnt[gi]),
      .any_grant (in_any[gi])
    );
    nebula_rr_arb #(.N(PORTS), .PTR_W(PORT_W)) u_out_arb (
      .req       (out_req[gi]),
      .ptr       (out_ptr[gi]),
      .gnt       (out_gnt[gi]),
      .any_grant (out_any[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      win_vc[i]   = '0;
      win_port[i] = '0;
      for (int v = 0; v < VCS; v++) begin
        if (in_gnt[i][v]) begin
          win_vc[i]   = VC_W'(v);
          win_port[i] = tgt[i][v];
        end
      end
    end
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        out_req[o][i] = in_any[i] && (win_port[i] == PORT_W'(o));
      end
    end
  end

  always_comb begin
    grant      = '0;
    in_won     = '0;
    shead      = '0;
    stail      = '0;
    xbar_sel   = '0;
    xbar_vc    = '0;
    xbar_valid = out_any & {PORTS{!rst}};
    for (int o = 0; o < PORTS; o++) begin
      sel[o] = '0;
      svc[o] = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (out_gnt[o][i]) begin
          in_won[i] = 1'b1;
          sel[o]    = PORT_W'(i);
          svc[o]    = win_vc[i];
          for (int v = 0; v < VCS; v++) begin
            if (in_gnt[i][v]) begin
              shead[o] = req_head[i*VCS+v];
              stail[o] = req_tail[i*VCS+v];
            end
          end
        end
      end
      xbar_sel[o*PORT_W +: PORT_W] = sel[o];
      xbar_vc[o*VC_W +: VC_W]      = svc[o];
    end
    for (int i = 0; i < PORTS; i++) begin
      for (int v = 0; v < VCS; v++) begin
        grant[i*VCS+v] = !rst && in_won[i] && in_gnt[i][v];
      end
    end
  end

  // A flit keeps its VC, so the granted output's VC names the counter to decrement.
  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      congest_nxt[o] = 1'b0;
      for (int v = 0; v < VCS; v++) begin
        dec[o][v]        = xbar_valid[o] && (svc[o] == VC_W'(v));
        credit_nxt[o][v] = credit[o][v];
        if (dec[o][v] && !credit_ret[o*VCS+v]) begin
          credit_nxt[o][v] = credit[o][v] - CRED_W'(1);
        end else if (!dec[o][v] && credit_ret[o*VCS+v] && credit[o][v] != CRED_W'(CREDITS)) begin
          credit_nxt[o][v] = credit[o][v] + CRED_W'(1);
        end
        if (credit_nxt[o][v] == '0) begin
          congest_nxt[o] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      congest <= '0;
      for (int o = 0; o < PORTS; o++) begin
        lock[o]    <= '0;
        out_ptr[o] <= '0;
        in_ptr[o]  <= '0;
        for (int v = 0; v < VCS; v++) begin
          credit[o][v] <= CRED_W'(CREDITS);
        end
      end
    end else begin
      congest <= congest_nxt;
      for (int o = 0; o < PORTS; o++) begin
        for (int v = 0; v < VCS; v++) begin
          credit[o][v] <= credit_nxt[o][v];
        end
        if (xbar_valid[o]) begin
          out_ptr[o] <= (sel[o] == PORT_W'(PORTS-1)) ? '0 : sel[o] + PORT_W'(1);
          if (stail[o]) begin
            lock[o] <= '0;
          end else if (shead[o]) begin
            lock[o] <= '{valid: 1'b1, in: port_idx_t'(sel[o]), vc: vc_idx_t'(svc[o])};
          end
        end
      end
      for (int i = 0; i < PORTS; i++) begin
        if (in_won[i]) begin
          in_ptr[i] <= (win_vc[i] == VC_W'(VCS-1)) ? '0 : win_vc[i] + VC_W'(1);
        end
      end
    end
  end

  // Returning a credit to a full counter means upstream and downstream disagree on depth.
  always @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < PORTS; o++) begin
        for (int v = 0; v < VCS; v++) begin
          assert (!(credit_ret[o*VCS+v] && !dec[o][v] && credit[o][v] == CRED_W'(CREDITS)))
            else $warning("nebula_sw_alloc: credit return at full count, output %0d vc %0d", o, v);
        end
      end
    end
  end

endmodule

// File: doc/nebula_sw_alloc.md
Name: nebula_sw_alloc

Overview:
- Per-router switch allocator and output-credit manager for nebula_router (5 ports, per-port VCs).
- Each input-VC head flit requests one output port. The block issues at most one grant per input and per output each cycle.
- Wormhole: an output stays locked to the winning input-VC from head to tail.
- Tracks downstream credits per output per VC and drives the crossbar selects and the router's congest vector.

Parameters:
- PORTS, 5, number of router ports (index 4 = local).
- VCS, 2, virtual channels per port; a flit keeps its VC across the hop.
- CREDITS, 4, downstream FIFO depth per VC; reset value of each credit counter.
- PORT_W, $clog2(PORTS), width of an output-port index.
- CRED_W, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  PORTS*VCS  input-VC has a flit at FIFO head; bit index = i*VCS+v
- req_head  in  PORTS*VCS  head flag of that flit
- req_tail  in  PORTS*VCS  tail flag of that flit
- req_port  in  PORTS*VCS*PORT_W  requested output port (route compute result)
- credit_ret  in  PORTS*VCS  one credit returned by downstream of output o, VC v
- grant  out  PORTS*VCS  flit at input-VC dequeued this cycle; at most one bit per input
- xbar_valid  out  PORTS  output o transmits this cycle
- xbar_sel  out  PORTS*PORT_W  input index driving output o
- xbar_vc  out  PORTS*$clog2(VCS)  VC of the flit on output o
- congest  out  PORTS  registered; 1 when any VC credit of output o is 0

Behaviour:
- Allocation is combinational from the current inputs and registered state. grant and xbar_* are valid in the same cycle. State updates on the rising clk edge. Latency from request to grant is 0 cycles.
- Eligibility of input-VC (i,v) targeting output o: all of the following must hold.
  - req_valid is 1.
  - credit[o][v] > 0.
  - Either lock[o] is free and req_head=1, or lock[o] is owned by (i,v).
  - req_port < PORTS. An out-of-range value is never eligible.
- Stage 1 (input arbitration): each input picks one eligible VC by round-robin, starting from in_ptr[i].
- Stage 2 (output arbitration): each output picks one input among those whose stage-1 winner targets it, by round-robin starting from out_ptr[o].
- A locked output only ever sees its owner's requests, so the lock is honoured implicitly.
- Pointer update: on a grant, in_ptr[i] = winning v+1 mod VCS and out_ptr[o] = winning i+1 mod PORTS. Pointers are unchanged when there is no grant.
- Lock update on grant:
  - head=1 and tail=0: lock[o] := (i,v).
  - tail=1: lock[o] := free. This covers a single-flit head+tail, which never locks.
- Credits: a grant decrements credit[o][v]; credit_ret increments it. Both in the same cycle leaves it unchanged.
- A credit return at CREDITS without a decrement is a protocol error: the counter saturates and a simulation assertion fires.
- A grant never occurs at credit 0.
- congest[o] is registered from the post-update credits, so it is visible one cycle after the counter reaches 0.
- Reset (async, on rst=1): all credits = CREDITS, all locks free, all pointers 0, congest = 0.
  - grant and xbar_valid are forced to 0 while rst=1.
  - A packet in flight at reset loses its lock; upstream flushes are the router's responsibility.
- A self-route (req_port == i) is permitted; the local loopback 4->4 is legal.

Decomposition:
- Package nebula_pkg gets the shared constants (NUM_PORTS, PORT_LOCAL=4, NUM_VCS) and typedefs port_idx_t and vc_idx_t. It also gets the lock_t struct {valid, port_idx_t in, vc_idx_t vc}.
- Sub-module nebula_rr_arb #(N): a request vector plus pointer in, a one-hot grant plus any_grant out, purely combinational. It is instantiated PORTS times for input arbitration and PORTS times for output arbitration.
- Credit counters, locks and pointers live in nebula_sw_alloc.

Test Plan:
- Single flit, head+tail, input 4 VC0 to port 4: grant[8]=1, xbar_sel[4]=4, xbar_valid[4]=1 in the same cycle. credit[4][0] goes 4->3, no lock, and congest stays 0.
- Contention: inputs 0,1,2 each send continuous single-flit VC0 traffic to port 3. Grants rotate 0,1,2,0,... one per cycle, with credit_ret[3*VCS+0] pulsed each cycle to sustain the flow.
- Wormhole: input 1 VC1 sends head, body, body, tail to port 0 while input 2 VC1 requests port 0 with a head. Input 2 is granted only on the cycle after input 1's tail grant.
- Credit exhaustion: with no returns, a 5-flit packet stalls after 4 grants and congest[o] rises the cycle after the 4th grant. One credit_ret releases the 5th flit, and congest falls one cycle later.
- Simultaneous grant and credit_ret on the same counter: the value stays the same. Return at full count: the counter stays at 4 and the assertion fires.
- Assert rst mid-packet while an output is locked: grant=0 immediately. After release, a new head from another input wins that output and all credits read 4.
